risc_toy_fetch: RTL and testbench

Instruction fetch stage for the RISC_TOY pipeline. It owns the program counter, drives the instruction-memory request port (IREQ/IADDR) and captures INSTR. It hands instructions to the decode stage through a 2-entry skid buffer with a valid/stall handshake. Redirects from execute (branch, jump, JL/BRL) flush the buffer and discard the in-flight fetch.

---
 rtl/risc_toy_fetch.sv | 131 +++++++++++++
 tb/tb_risc_toy_fetch.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/risc_toy_fetch.sv
// risc_toy_fetch -- instruction fetch stage for the RISC_TOY pipeline.
//
// Owns the program counter and issues one instruction-memory request per
// cycle whenever the 2-entry skid buffer can absorb the response. Responses
// arrive one cycle after the request. Entry 0 of the buffer drives the
// fetch/decode (FD_*) outputs. A redirect from execute flushes the buffer,
// drops the response returning that cycle and fetches the target
// immediately.
//
// Ports:
//   CLK          in   clock, rising edge
//   RSTN         in   asynchronous active-low reset
//   IREQ         out  instruction-memory request
//   IADDR[29:0]  out  word address of the request
//   INSTR[31:0]  in   memory data for the request issued last cycle
//   STALL        in   decode cannot accept this cycle
//   REDIRECT     in   control-flow change from execute
//   REDIRECT_PC  in   redirect target byte address (bits [1:0] ignored)
//   FD_VALID     out  FD_* hold a valid instruction
//   FD_INSTR     out  instruction word
//   FD_PC        out  byte address of FD_INSTR
//   FD_NPC       out  FD_PC + 4 (link value)
module risc_toy_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IREQ,
  output logic [29:0] IADDR,
  input  logic [31:0] INSTR,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        FD_VALID,
  output logic [31:0] FD_INSTR,
  output logic [31:0] FD_PC,
  output logic [31:0] FD_NPC
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] infl_pc_q, infl_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];
  logic [31:0] bpc_q   [2];
  logic [31:0] bpc_d   [2];

  logic        consume;
  logic [2:0]  occupancy;
  logic        wr_idx;
  logic [31:0] target_pc;

  assign target_pc = REDIRECT_PC & ~32'h0000_0003;

  assign FD_VALID = (count_q != 2'd0);
  assign FD_INSTR = instr_q[0];
  assign FD_PC    = bpc_q[0];
  // Held at zero while nothing is valid so the output reads 0 out of reset.
  assign FD_NPC   = FD_VALID ? (bpc_q[0] + 32'd4) : 32'd0;

  assign consume = FD_VALID & ~STALL & ~REDIRECT;

  // Entries the buffer will hold after this cycle if no new request is made;
  // a request is only allowed when at most one is committed, so the
  // response always finds a free slot.
  assign occupancy = {1'b0, count_q} - {2'b00, consume} + {2'b00, inflight_q};

  assign IREQ  = RSTN & (REDIRECT | (occupancy <= 3'd1));
  assign IADDR = (RSTN & REDIRECT) ? target_pc[31:2] : pc_q[31:2];

  // The returning word goes to the first free slot after the consume shift.
  assign wr_idx = ((count_q - {1'b0, consume}) != 2'd0);

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    infl_pc_d  = infl_pc_q;
    count_d    = count_q;
    instr_d    = instr_q;
    bpc_d      = bpc_q;

    if (REDIRECT) begin
      // Flush: the buffer contents and the response arriving now are dropped.
      count_d    = 2'd0;
      pc_d       = target_pc + 32'd4;
      inflight_d = 1'b1;
      infl_pc_d  = target_pc;
    end else begin
      if (consume) begin
        instr_d[0] = instr_q[1];
        bpc_d[0]   = bpc_q[1];
      end
      if (inflight_q) begin
        instr_d[wr_idx] = INSTR;
        bpc_d[wr_idx]   = infl_pc_q;
      end
      count_d = occupancy[1:0];
      if (IREQ) begin
        pc_d       = pc_q + 32'd4;
        inflight_d = 1'b1;
        infl_pc_d  = pc_q;
      end else begin
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q  <= 32'd0;
      count_q    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= 32'd0;
        bpc_q[i]   <= 32'd0;
      end
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      infl_pc_q  <= infl_pc_d;
      count_q    <= count_d;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= instr_d[i];
        bpc_q[i]   <= bpc_d[i];
      end
    end
  end

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed testbench for risc_toy_fetch. Two instances run side by side:
// dut with RESET_PC=0 and dut_w with RESET_PC=FFFF_FFF8 (address wrap).
// Each has a memory model that returns the requested word address as data.
module tb_risc_toy_fetch;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;

  logic        ireq,   ireq_w;
  logic [29:0] iaddr,  iaddr_w;
  logic [31:0] instr,  instr_w;
  logic        fd_valid, fd_valid_w;
  logic [31:0] fd_instr, fd_instr_w;
  logic [31:0] fd_pc,    fd_pc_w;
  logic [31:0] fd_npc,   fd_npc_w;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  risc_toy_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RSTN(RSTN), .IREQ(ireq), .IADDR(iaddr), .INSTR(instr),
    .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .FD_VALID(fd_valid), .FD_INSTR(fd_instr), .FD_PC(fd_pc), .FD_NPC(fd_npc)
  );

  risc_toy_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .CLK(CLK), .RSTN(RSTN), .IREQ(ireq_w), .IADDR(iaddr_w), .INSTR(instr_w),
    .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .FD_VALID(fd_valid_w), .FD_INSTR(fd_instr_w), .FD_PC(fd_pc_w), .FD_NPC(fd_npc_w)
  );

  // Memory: data in cycle t+1 is the word address requested in cycle t.
  always @(posedge CLK) begin
    instr   <= ireq   ? {2'b00, iaddr}   : 32'hBAD0_BAD0;
    instr_w <= ireq_w ? {2'b00, iaddr_w} : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic fd(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, fd_valid}, 32'd1);
    chk({tag, "_pc"},    fd_pc,             pc);
    chk({tag, "_instr"}, fd_instr,          {2'b00, pc[31:2]});
    chk({tag, "_npc"},   fd_npc,            pc + 32'd4);
    $display("FD pc=%h instr=%h npc=%h", fd_pc, fd_instr, fd_npc);
  endtask

  task automatic fd_w(input string tag, input logic [31:0] pc);
    chk({tag, "_w_valid"}, {31'd0, fd_valid_w}, 32'd1);
    chk({tag, "_w_pc"},    fd_pc_w,             pc);
    chk({tag, "_w_instr"}, fd_instr_w,          {2'b00, pc[31:2]});
    chk({tag, "_w_npc"},   fd_npc_w,            pc + 32'd4);
    $display("FDW pc=%h instr=%h npc=%h", fd_pc_w, fd_instr_w, fd_npc_w);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    RSTN = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'd0;

    // Reset state
    step();
    chk("rst_ireq",   {31'd0, ireq},     32'd0);
    chk("rst_iaddr",  {2'b00, iaddr},    32'd0);
    chk("rst_valid",  {31'd0, fd_valid}, 32'd0);
    chk("rst_instr",  fd_instr,          32'd0);
    chk("rst_pc",     fd_pc,             32'd0);
    chk("rst_npc",    fd_npc,            32'd0);
    chk("rst_iaddr_w", {2'b00, iaddr_w}, 32'h3FFF_FFFE);

    // First cycle after reset release
    RSTN = 1'b1; #1;
    chk("first_ireq",  {31'd0, ireq},    32'd1);
    chk("first_iaddr", {2'b00, iaddr},   32'd0);
    chk("first_iaddr_w", {2'b00, iaddr_w}, 32'h3FFF_FFFE);
    step();
    chk("lat_valid", {31'd0, fd_valid}, 32'd0);
    step();

    // Streaming: one instruction per cycle
    fd("s0", 32'h0);   fd_w("s0", 32'hFFFF_FFF8); step();
    fd("s1", 32'h4);   fd_w("s1", 32'hFFFF_FFFC); step();
    fd("s2", 32'h8);   fd_w("s2", 32'h0000_0000);

    // Stall 3 cycles with FD_PC=8; address 12 still lands
    STALL = 1'b1; #1;
    chk("stall1_ireq", {31'd0, ireq}, 32'd0);
    step(); fd("stall2", 32'h8); chk("stall2_ireq", {31'd0, ireq}, 32'd0);
    step(); fd("stall3", 32'h8); chk("stall3_ireq", {31'd0, ireq}, 32'd0);
    step(); fd("rel0", 32'h8);
    STALL = 1'b0; #1;
    chk("rel_ireq",  {31'd0, ireq},  32'd1);
    chk("rel_iaddr", {2'b00, iaddr}, 32'd4);
    step(); fd("rel1", 32'hC); fd_w("rel1", 32'h4);
    step(); fd("rel2", 32'h10);

    // Redirect while streaming
    REDIRECT = 1'b1; REDIRECT_PC = 32'h100; #1;
    chk("redir_ireq",  {31'd0, ireq},  32'd1);
    chk("redir_iaddr", {2'b00, iaddr}, 32'h40);
    step(); REDIRECT = 1'b0;
    chk("redir_gap", {31'd0, fd_valid}, 32'd0);
    step(); fd("redir_t0", 32'h100);
    step(); fd("redir_t1", 32'h104);

    // Redirect during stall with two entries buffered
    STALL = 1'b1;
    step(); fd("full", 32'h104);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h203; #1;
    chk("rs_iaddr", {2'b00, iaddr}, 32'h80);
    chk("rs_ireq",  {31'd0, ireq},  32'd1);
    step(); REDIRECT = 1'b0; STALL = 1'b0;
    chk("rs_gap", {31'd0, fd_valid}, 32'd0);
    step(); fd("rs_t0", 32'h200);
    step(); fd("rs_t1", 32'h204);

    // Back-to-back redirects: only the last target survives
    REDIRECT = 1'b1; REDIRECT_PC = 32'h300;
    step(); REDIRECT_PC = 32'h400; #1;
    chk("rr_iaddr", {2'b00, iaddr}, 32'h100);
    step(); REDIRECT = 1'b0;
    chk("rr_gap", {31'd0, fd_valid}, 32'd0);
    step(); fd("rr_t0", 32'h400);
    step(); fd("rr_t1", 32'h404);

    // Asynchronous reset mid-stream with a request in flight
    #2 RSTN = 1'b0; #1;
    chk("arst_valid", {31'd0, fd_valid}, 32'd0);
    chk("arst_ireq",  {31'd0, ireq},     32'd0);
    chk("arst_iaddr", {2'b00, iaddr},    32'd0);
    chk("arst_pc",    fd_pc,             32'd0);
    step(); RSTN = 1'b1; #1;
    chk("rest_ireq",  {31'd0, ireq},  32'd1);
    chk("rest_iaddr", {2'b00, iaddr}, 32'd0);
    step();
    chk("rest_gap", {31'd0, fd_valid}, 32'd0);
    step(); fd("rest_t0", 32'h0);
    step(); fd("rest_t1", 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
